i2c_txn_arbiter: RTL

I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_rr_pick.sv | 13 +
 rtl/i2c_txn_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C transaction arbiter: master state codes,
// arbiter FSM states and the default launch timeout.
package i2c_pkg;

  localparam int LAUNCH_TIMEOUT_DEF = 255;

  typedef enum logic [3:0] {
    MS_IDLE           = 4'd0,
    MS_START          = 4'd1,
    MS_SEND_ADDR      = 4'd2,
    MS_CHECK_ACK_ADDR = 4'd3,
    MS_SEND_DATA      = 4'd4,
    MS_CHECK_ACK_DATA = 4'd5,
    MS_READ_DATA      = 4'd6,
    MS_SEND_ACK       = 4'd7,
    MS_STOP           = 4'd8
  } master_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_BUSY,
    ARB_DONE
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Two-way round-robin pick: ptr names the requester favoured on contention.
module i2c_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates two transaction requesters onto one I2C master: latches the
// winner's transaction, launches it, tracks completion/NACK and reports done.
module i2c_txn_arbiter import i2c_pkg::*; #(
  parameter int ADDR_LEN       = 7,
  parameter int DATA_LEN       = 8,
  parameter int LAUNCH_TIMEOUT = LAUNCH_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic [ADDR_LEN-1:0]   addr_0,
  input  logic [ADDR_LEN-1:0]   addr_1,
  input  logic                  rw_0,
  input  logic                  rw_1,
  input  logic                  len_0,
  input  logic                  len_1,
  input  logic [2*DATA_LEN-1:0] wdata_0,
  input  logic [2*DATA_LEN-1:0] wdata_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  done_0,
  output logic                  done_1,
  output logic                  err,
  output logic [2*DATA_LEN-1:0] rdata,
  output logic                  start,
  output logic [ADDR_LEN-1:0]   add_reg,
  output logic                  R_W,
  output logic [DATA_LEN-1:0]   data_1,
  output logic [DATA_LEN-1:0]   data_2,
  output logic                  ack_3p,
  input  logic                  free,
  input  logic [3:0]            state_master,
  input  logic [DATA_LEN-1:0]   dout_1,
  input  logic [DATA_LEN-1:0]   dout_2
);

  localparam logic [7:0] TIMEOUT8 = 8'(LAUNCH_TIMEOUT);

  arb_state_e state, state_next;
  logic [1:0] gnt, pick;
  logic       ptr, nack, to_err, load, timeout, sm_nack, fail;
  logic [7:0] cnt;
  logic [3:0] prev_sm;
  logic [2*DATA_LEN-1:0] wsel;

  i2c_rr_pick u_pick (
    .req ({req_1, req_0}),
    .ptr (ptr),
    .gnt (pick)
  );

  assign wsel    = pick[1] ? wdata_1 : wdata_0;
  assign sm_nack = (state == ARB_BUSY) && (prev_sm == 4'(MS_CHECK_ACK_ADDR))
                   && (state_master == 4'(MS_STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    timeout    = 1'b0;
    case (state)
      ARB_IDLE: if (free && |pick) begin
        load       = 1'b1;
        state_next = ARB_LAUNCH;
      end
      ARB_LAUNCH: begin
        if (!free) state_next = ARB_BUSY;
        else if (cnt + 8'd1 == TIMEOUT8) begin
          timeout    = 1'b1;
          state_next = ARB_DONE;
        end
      end
      ARB_BUSY: if (free) state_next = ARB_DONE;
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Transaction fields are loaded only at grant, so they hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      start   <= 1'b0;
      add_reg <= '0;
      R_W     <= 1'b0;
      data_1  <= '0;
      data_2  <= '0;
      ack_3p  <= 1'b0;
      cnt     <= '0;
      nack    <= 1'b0;
      to_err  <= 1'b0;
      ptr     <= 1'b0;
      prev_sm <= '0;
    end else begin
      prev_sm <= state_master;
      if (load) begin
        gnt     <= pick;
        start   <= 1'b1;
        add_reg <= pick[1] ? addr_1 : addr_0;
        R_W     <= pick[1] ? rw_1 : rw_0;
        ack_3p  <= pick[1] ? len_1 : len_0;
        data_1  <= wsel[2*DATA_LEN-1:DATA_LEN];
        data_2  <= wsel[DATA_LEN-1:0];
        cnt     <= '0;
      end
      if (state == ARB_LAUNCH) begin
        cnt <= cnt + 8'd1;
        if (state_next != ARB_LAUNCH) start <= 1'b0;
      end
      if (timeout) to_err <= 1'b1;
      if (sm_nack) nack <= 1'b1;
      if (state == ARB_DONE) begin
        gnt    <= '0;
        nack   <= 1'b0;
        to_err <= 1'b0;
        cnt    <= '0;
        ptr    <= gnt[0];
      end
    end
  end

  assign fail   = nack || to_err;
  assign gnt_0  = gnt[0];
  assign gnt_1  = gnt[1];
  assign done_0 = (state == ARB_DONE) && gnt[0];
  assign done_1 = (state == ARB_DONE) && gnt[1];
  assign err    = (state == ARB_DONE) && fail;
  // Failed transactions carry no read data.
  assign rdata  = (state == ARB_DONE && R_W && !fail) ? {dout_1, dout_2} : '0;

endmodule
